// File: rtl/imm_gen_pkg.sv
// Shared opcode constants, immediate format codes and sign-extension helper
// for the decode-stage immediate generator.
package imm_gen_pkg;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] IMM_FMT_R    = 3'd0;
  localparam logic [2:0] IMM_FMT_I    = 3'd1;
  localparam logic [2:0] IMM_FMT_S    = 3'd2;
  localparam logic [2:0] IMM_FMT_B    = 3'd3;
  localparam logic [2:0] IMM_FMT_U    = 3'd4;
  localparam logic [2:0] IMM_FMT_J    = 3'd5;
  localparam logic [2:0] IMM_FMT_NONE = 3'd7;

  // Widest supported XLEN is 64; narrower users take the 32-bit value as-is.
  function automatic logic [63:0] sext_to_xlen(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word to sign-extended
// immediate, format code and illegal flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  // Every format puts instr[31] in bit 31 of imm32, so widening is a plain sext.
  always_comb begin
    imm32   = '0;
    fmt     = IMM_FMT_NONE;
    illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
          imm32   = {{20{instr[31]}}, instr[31:20]};
          fmt     = IMM_FMT_I;
          illegal = 1'b0;
        end
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            imm32   = {{20{instr[31]}}, instr[31:20]};
            fmt     = IMM_FMT_I;
            illegal = 1'b0;
          end
        end
        OPC_STORE: begin
          imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          fmt     = IMM_FMT_S;
          illegal = 1'b0;
        end
        OPC_BRANCH: begin
          imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt     = IMM_FMT_B;
          illegal = 1'b0;
        end
        OPC_LUI, OPC_AUIPC: begin
          imm32   = {instr[31:12], 12'b0};
          fmt     = IMM_FMT_U;
          illegal = 1'b0;
        end
        OPC_JAL: begin
          imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt     = IMM_FMT_J;
          illegal = 1'b0;
        end
        OPC_OP: begin
          fmt     = IMM_FMT_R;
          illegal = 1'b0;
        end
        OPC_OP_32: begin
          if (XLEN == 64) begin
            fmt     = IMM_FMT_R;
            illegal = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  if (XLEN == 64) begin : g_x64
    assign imm = sext_to_xlen(imm32);
  end else begin : g_x32
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode + pc-relative target on the input side,
// registered behind a 2-entry main/skid buffer.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target
);

  // Handshake: a beat moves on a side at a rising edge where valid && ready;
  // valid never waits on ready, and out_* hold while out_valid && !out_ready.
  localparam int EW = 32 + 3 * XLEN + 3 + 1;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;
  logic [EW-1:0]   in_entry;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          accept, drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_target = in_pc + dec_imm;
  assign in_entry   = {in_instr, in_pc, dec_imm, dec_target, dec_fmt, dec_illegal};

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid_q && out_ready;

  assign {out_instr, out_pc, out_imm, out_target, out_fmt, out_illegal} = main_q;

  // A full skid forces in_ready low, so the skid-promote branch never sees an accept.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || drain)) begin
      main_d       = in_entry;
      main_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  if (RESET_PC_ZERO) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        main_q <= main_d;
        skid_q <= skid_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus, each
// with its own expected queue checked against an arithmetic reference model.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;
  logic        rand_ready_en = 1'b0;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_instr32, out_pc32, out_imm32, out_target32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_pc64, out_imm64, out_target64;
  logic [2:0]  out_fmt64;

  exp_t exp_q32[$];
  exp_t exp_q64[$];
  exp_t e32, e64;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] opcs [14] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h1B, 7'h23,
                            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0B};

  imm_gen_pipe #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32),
    .out_pc(out_pc32), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_target(out_target32)
  );

  imm_gen_pipe #(.XLEN(64), .RESET_PC_ZERO(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
    .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_target(out_target64)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] asr(input logic [63:0] v, input int n);
    return 64'($signed(v) >>> n);
  endfunction

  function automatic exp_t model(input logic [31:0] instr, input logic [63:0] pc, input int xlen);
    exp_t        e;
    logic [63:0] w, mask;
    int          f;
    w    = {{32{instr[31]}}, instr};
    mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    f    = 7;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: f = 1;
        7'h1B: f = (xlen == 64) ? 1 : 7;
        7'h23: f = 2;
        7'h63: f = 3;
        7'h37, 7'h17: f = 4;
        7'h6F: f = 5;
        7'h33: f = 0;
        7'h3B: f = (xlen == 64) ? 0 : 7;
        default: f = 7;
      endcase
    end
    case (f)
      1: e.imm = asr(w, 20);
      2: e.imm = (asr(w, 25) << 5) | 64'(instr[11:7]);
      3: e.imm = (asr(w, 31) << 12) | (64'(instr[7]) << 11) | (64'(instr[30:25]) << 5)
                 | (64'(instr[11:8]) << 1);
      4: e.imm = asr(w, 12) << 12;
      5: e.imm = (asr(w, 31) << 20) | (64'(instr[19:12]) << 12) | (64'(instr[20]) << 11)
                 | (64'(instr[30:21]) << 1);
      default: e.imm = 64'd0;
    endcase
    e.instr = instr;
    e.pc    = pc & mask;
    e.imm   = e.imm & mask;
    e.tgt   = (e.pc + e.imm) & mask;
    e.fmt   = 3'(f);
    e.ill   = (f == 7);
    return e;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send(input logic [31:0] instr, input logic [63:0] pc);
    int   n;
    logic rdy;
    n        = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    do begin
      @(negedge clk);
      rdy = in_ready32;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout instr=%08h not accepted in %0d cycles", instr, n);
    end else begin
      exp_q32.push_back(model(instr, pc, 32));
      exp_q64.push_back(model(instr, pc, 64));
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic with_input);
    flush    = 1'b1;
    in_valid = with_input;
    in_instr = $urandom;
    in_pc    = {$urandom, $urandom};
    @(posedge clk);
    exp_q32.delete();
    exp_q64.delete();
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && !flush) begin
      cmp("out_valid32", 64'(out_valid32), 64'(exp_q32.size() > 0));
      cmp("in_ready32", 64'(in_ready32), 64'(exp_q32.size() < 2));
      if (out_valid32 && exp_q32.size() > 0) begin
        e32 = exp_q32[0];
        cmp("instr32", 64'(out_instr32), 64'(e32.instr));
        cmp("pc32", 64'(out_pc32), e32.pc);
        cmp("imm32", 64'(out_imm32), e32.imm);
        cmp("target32", 64'(out_target32), e32.tgt);
        cmp("fmt32", 64'(out_fmt32), 64'(e32.fmt));
        cmp("illegal32", 64'(out_illegal32), 64'(e32.ill));
        if (out_ready) void'(exp_q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && !flush) begin
      cmp("out_valid64", 64'(out_valid64), 64'(exp_q64.size() > 0));
      cmp("in_ready64", 64'(in_ready64), 64'(exp_q64.size() < 2));
      if (out_valid64 && exp_q64.size() > 0) begin
        e64 = exp_q64[0];
        cmp("instr64", 64'(out_instr64), 64'(e64.instr));
        cmp("pc64", out_pc64, e64.pc);
        cmp("imm64", out_imm64, e64.imm);
        cmp("target64", out_target64, e64.tgt);
        cmp("fmt64", 64'(out_fmt64), 64'(e64.fmt));
        cmp("illegal64", 64'(out_illegal64), 64'(e64.ill));
        if (out_ready) void'(exp_q64.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ri;
    logic [63:0] rp;
    int          k;

    rst_n = 1'b0;
    #1;
    cmp("rst_out_valid32", 64'(out_valid32), 64'd0);
    cmp("rst_in_ready32", 64'(in_ready32), 64'd1);
    cmp("rst_imm32", 64'(out_imm32), 64'd0);
    cmp("rst_target32", 64'(out_target32), 64'd0);
    cmp("rst_out_valid64", 64'(out_valid64), 64'd0);
    cmp("rst_in_ready64", 64'(in_ready64), 64'd1);
    cmp("rst_pc64", out_pc64, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // addi x1,x0,-1 then the mixed-format back-to-back burst
    out_ready = 1'b1;
    send(32'hFFF00093, 64'h0);
    send(32'hFE20AE23, 64'h0);
    send(32'hFE009CE3, 64'h100);
    send(32'h123452B7, 64'h104);
    send(32'h001000EF, 64'h200);
    idle(3);

    // five instructions into a three-cycle downstream stall
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send($urandom, {$urandom, $urandom});
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(4);

    // custom-0 and a compressed-looking word are both illegal
    send(32'h0000000B, 64'h300);
    send(32'h00000010, 64'h304);
    idle(3);

    // flush with two held entries and a simultaneous input
    out_ready = 1'b0;
    send(32'h00A00513, 64'h400);
    send(32'h00B00593, 64'h404);
    do_flush(1'b1);
    idle(1);
    out_ready = 1'b1;
    idle(4);

    // randomized traffic with random backpressure and occasional flushes
    rand_ready_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ri = $urandom;
      k  = $urandom_range(0, 15);
      if (k < 14) ri[6:0] = opcs[k];
      if ($urandom_range(0, 7) == 0) ri[1:0] = 2'($urandom_range(0, 2));
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) rp = 64'h0;
      send(ri, rp);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) do_flush(1'($urandom_range(0, 1)));
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    idle(5);

    // addiw (legal only at XLEN=64), then reset mid-stall
    send(32'hFFF0809B, 64'h500);
    idle(2);
    out_ready = 1'b0;
    send(32'h00000013, 64'h504);
    send(32'h00000033, 64'h508);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q32.delete();
    exp_q64.delete();
    #1;
    cmp("midrst_out_valid32", 64'(out_valid32), 64'd0);
    cmp("midrst_in_ready32", 64'(in_ready32), 64'd1);
    cmp("midrst_out_valid64", 64'(out_valid64), 64'd0);
    cmp("midrst_in_ready64", 64'(in_ready64), 64'd1);
    cmp("midrst_imm64", out_imm64, 64'd0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined immediate generator for the decode stage. It sits between the fetch/instruction register and decode/execute, and covers every RV32I format: I, S, B, U, J, plus R with a zero immediate. RV64 OP-IMM-32/OP-32 are added when XLEN=64. Each instruction gets a sign-extended XLEN immediate, a format code, an illegal flag and a PC-relative target (pc+imm). A valid/ready handshake with a 2-entry skid buffer gives full throughput and registered in_ready.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Also enables the RV64 opcodes.
RESET_PC_ZERO, 1, when 1 the data registers clear on reset; when 0 only the valid bits clear.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  block can accept; registered, equals !skid_valid
in_instr  input  32  raw instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_instr  output  32  instruction passed through
out_pc  output  XLEN  PC passed through
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  format code (IMM_FMT_* from package)
out_illegal  output  1  unsupported opcode or in_instr[1:0]!=2'b11
out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN

Behaviour:
- Reset (async assert, sync release): main_valid=0, skid_valid=0, so out_valid=0 and in_ready=1. Data outputs are 0 if RESET_PC_ZERO=1.
- Format decode on in_instr[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011, 0001111; 0011011 only when XLEN=64. imm = sext(instr[31:20]).
  - S: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}).
  - J: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 0110011; 0111011 only when XLEN=64. imm = 0.
  - Anything else, or instr[1:0]!=11: fmt=NONE, imm=0, illegal=1.
- Sign extension always uses instr[31] and extends to XLEN.
- Codes: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- Decode and target add happen combinationally on the input side. Results are captured in the registers, so outputs never depend combinationally on in_*.
- Latency: accepted in cycle N, the entry appears on out_* in cycle N+1.
- Handshake: a transfer happens when valid&&ready on a side. out_* stay stable while out_valid && !out_ready.
- Buffering:
  - Accept with main empty, or with main draining this cycle: write main.
  - Accept while main holds and is not draining: write skid. in_ready falls next cycle.
  - When main drains and skid is valid: skid moves to main and skid clears.
  - Order is strictly FIFO. Capacity is 2. Throughput is 1 per cycle when out_ready=1.
- flush=1 at a clock edge clears both valids; in_ready=1 the next cycle. An in_valid presented in the flush cycle is dropped. flush has priority over simultaneous accept and drain.
- Simultaneous accept and drain with skid empty: main is replaced, no bubble.
- Reset asserted mid-transfer: all entries are lost immediately, with no partial outputs.
- Target arithmetic wraps; e.g. pc 0x0 + imm -4 gives 0xFFFFFFFC for XLEN=32.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP_IMM_32, OPC_OP_32);
  - the IMM_FMT_* 3-bit codes;
  - a function sext_to_xlen.
- One sub-module, imm_decode: purely combinational, taking instr and producing imm, fmt and illegal, parametrised by XLEN.
- The top holds the adder and the main/skid registers.

Test Plan:
1. Reset with XLEN=32, then send pc 0x0 instr 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt=I, illegal=0, target=0xFFFFFFFF.
2. Send back-to-back 0xFE20AE23 (sw x2,-4(x1)), 0xFE009CE3 (bne x1,x0,-8, pc 0x100), 0x123452B7 (lui), 0x001000EF (jal +2048, pc 0x200), all with out_ready=1:
   - sw: imm 0xFFFFFFFC, fmt S.
   - bne: imm 0xFFFFFFF8, target 0xF8.
   - lui: imm 0x12345000, fmt U.
   - jal: imm 0x800, target 0xA00.
   - One output per cycle.
3. Stream 5 instructions with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepts, out_* stable while stalled, and all 5 emerge in order with no loss or duplication.
4. Send 0x0000000B (custom-0) and 0x00000013 with instr[1:0] forced to 00 -> fmt=NONE, imm=0, illegal=1 for both.
5. With 2 entries held, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, and the flush-cycle input never appears.
6. With XLEN=64, send 0xFFF0809B (addiw x1,x1,-1) -> imm 0xFFFFFFFFFFFFFFFF, fmt=I. Then assert rst_n=0 mid-stall -> out_valid=0 immediately.
